// File: rtl/dis_memory_pkg.sv
// Shared widths and types for the distributed data/instruction store.
// Defaults match the 1024 x 32 CPU memory-stage configuration.
package dis_memory_pkg;

    localparam int DIS_ADDR_WIDTH = 10;
    localparam int DIS_DATA_WIDTH = 32;
    localparam int DIS_BYTES      = DIS_DATA_WIDTH / 8;

    typedef logic [DIS_DATA_WIDTH-1:0] word_t;
    typedef logic [DIS_BYTES-1:0]      be_t;
    typedef logic [DIS_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/dis_memory_array.sv
// Raw LUT RAM: byte-enabled synchronous write, no reset.
// Latency: read combinational, write lands on the rising edge.
// Backpressure: none, always accepts.
module dis_memory_array
    import dis_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DIS_ADDR_WIDTH,
    parameter int DATA_WIDTH = DIS_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic [ADDR_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   d,
    input  logic [DATA_WIDTH/8-1:0] we,
    output logic [DATA_WIDTH-1:0]   spo
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem[a][8*i +: 8] <= d[8*i +: 8];
            end
        end
    end

    assign spo = mem[a];

endmodule

// File: rtl/dis_memory.sv
// 1024 x 32 distributed RAM with per-word valid bits standing in for a full clear.
// Latency: read combinational, write visible right after the rising edge.
// Backpressure: none, always accepts.
module dis_memory
    import dis_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DIS_ADDR_WIDTH,
    parameter int DATA_WIDTH = DIS_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   d,
    input  logic [DATA_WIDTH/8-1:0] we,
    output logic [DATA_WIDTH-1:0]   spo
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DEPTH-1:0]      vld;
    logic [BYTES-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  wr_any;

    // Reset only clears vld, so the LUT RAM itself carries no reset fanout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (wr_any) begin
            vld[a] <= 1'b1;
        end
    end

    assign wr_any = rst_n && (|we);

    // First write to an invalid word stores all bytes so stale RAM contents
    // under disabled byte lanes are replaced by zero.
    always_comb begin
        wr_dat = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                wr_dat[8*i +: 8] = d[8*i +: 8];
            end
        end
        wr_be = '0;
        if (wr_any) begin
            wr_be = vld[a] ? we : {BYTES{1'b1}};
        end
    end

    dis_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk (clk),
        .a   (a),
        .d   (wr_dat),
        .we  (wr_be),
        .spo (rd_dat)
    );

    assign spo = vld[a] ? rd_dat : '0;

endmodule

// File: tb/tb_dis_memory.sv
// Directed bench for dis_memory: reset, writes, byte enables, read-during-write, async reset.
module tb_dis_memory;
    import dis_memory_pkg::*;

    logic  clk;
    logic  rst_n;
    addr_t a;
    word_t d;
    be_t   we;
    word_t spo;

    int vectors;
    int miscompares;

    dis_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .d     (d),
        .we    (we),
        .spo   (spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input addr_t wa, input word_t wd, input be_t wbe);
        @(negedge clk);
        a  = wa;
        d  = wd;
        we = wbe;
        @(posedge clk);
        #1;
        we = '0;
    endtask

    task automatic test_reset();
        addr_t addrs [4];
        addrs[0] = 10'd0;
        addrs[1] = 10'd1;
        addrs[2] = 10'd2;
        addrs[3] = 10'd1023;
        rst_n = 1'b0;
        we = '0;
        d  = '0;
        a  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = addrs[i];
            #1;
            vectors++;
            if (spo !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read a=%0d got=%h exp=%h", a, spo, 32'h0);
            end
        end
    endtask

    task automatic test_full_word();
        addr_t ra  [4];
        word_t exp [4];
        do_write(10'd0, 32'h1, 4'hF);
        do_write(10'd1, 32'h2, 4'hF);
        ra[0] = 10'd2; exp[0] = 32'h0;
        ra[1] = 10'd1; exp[1] = 32'h2;
        ra[2] = 10'd2; exp[2] = 32'h0;
        ra[3] = 10'd0; exp[3] = 32'h1;
        for (int i = 0; i < 4; i++) begin
            a = ra[i];
            #1;
            vectors++;
            if (spo !== exp[i]) begin
                miscompares++;
                $display("FAIL full_word a=%0d got=%h exp=%h", a, spo, exp[i]);
            end
        end
    endtask

    task automatic test_byte_enables();
        do_write(10'd5, 32'hAABBCCDD, 4'hF);
        do_write(10'd5, 32'h11223344, 4'b0101);
        vectors++;
        if (spo !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL byte_merge got=%h exp=%h", spo, 32'hAA22CC44);
        end
        do_write(10'd6, 32'h11223344, 4'b0010);
        vectors++;
        if (spo !== 32'h00003300) begin
            miscompares++;
            $display("FAIL byte_fresh got=%h exp=%h", spo, 32'h00003300);
        end
    endtask

    task automatic test_max_address();
        do_write(10'd1023, 32'hFFFF_FFFF, 4'hF);
        vectors++;
        if (spo !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL max_addr got=%h exp=%h", spo, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_read_during_write();
        do_write(10'd7, 32'h5, 4'hF);
        @(negedge clk);
        a  = 10'd7;
        d  = 32'h9;
        we = 4'hF;
        #1;
        vectors++;
        if (spo !== 32'h5) begin
            miscompares++;
            $display("FAIL rdw_before got=%h exp=%h", spo, 32'h5);
        end
        @(posedge clk);
        #1;
        we = '0;
        vectors++;
        if (spo !== 32'h9) begin
            miscompares++;
            $display("FAIL rdw_after got=%h exp=%h", spo, 32'h9);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 10'd1;
        #1;
        vectors++;
        if (spo !== 32'h2) begin
            miscompares++;
            $display("FAIL areset_pre got=%h exp=%h", spo, 32'h2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (spo !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_immediate got=%h exp=%h", spo, 32'h0);
        end
        d  = 32'hDEAD_BEEF;
        we = 4'hF;
        @(posedge clk);
        #1;
        vectors++;
        if (spo !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_write_dropped got=%h exp=%h", spo, 32'h0);
        end
        @(negedge clk);
        we = '0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (spo !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_after_a1 got=%h exp=%h", spo, 32'h0);
        end
        a = 10'd0;
        #1;
        vectors++;
        if (spo !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_after_a0 got=%h exp=%h", spo, 32'h0);
        end
        // Stale RAM byte 0 of word 1 must not resurface on a partial write.
        do_write(10'd1, 32'h0000_CD00, 4'b0010);
        vectors++;
        if (spo !== 32'h0000_CD00) begin
            miscompares++;
            $display("FAIL areset_partial got=%h exp=%h", spo, 32'h0000_CD00);
        end
    endtask

    task automatic test_no_write();
        word_t ds [3];
        ds[0] = 32'hCAFE_F00D;
        ds[1] = 32'h0BAD_0BAD;
        ds[2] = 32'hFFFF_0000;
        do_write(10'd3, 32'h1234_5678, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a  = 10'd3;
            d  = ds[i];
            we = '0;
            @(posedge clk);
            #1;
            vectors++;
            if (spo !== 32'h1234_5678) begin
                miscompares++;
                $display("FAIL no_write edge=%0d got=%h exp=%h", i, spo, 32'h1234_5678);
            end
        end
        a = 10'd4;
        #1;
        vectors++;
        if (spo !== 32'h0) begin
            miscompares++;
            $display("FAIL no_write_a4 got=%h exp=%h", spo, 32'h0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_full_word();
        test_byte_enables();
        test_max_address();
        test_read_during_write();
        test_async_reset();
        test_no_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
